rr_xbar_sched_4: RTL and testbench
==================================

RR_XBAR_SCHED_4 -- requirements
Module: rr_xbar_sched_4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the data lane width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, [3:0]: per-lane request valid.
REQ-005 The block SHALL have port in_data, input, [3:0][WIDTH-1:0]: per-lane request payload.
REQ-006 The block SHALL have port in_ready, output, [3:0]: per-lane accept; at most one bit is high per cycle.
REQ-007 The block SHALL have port out_valid, output, [3:0]: per-lane delivered-payload valid.
REQ-008 The block SHALL have port out_data, output, [3:0][WIDTH-1:0]: per-lane delivered payload.
REQ-009 The block SHALL have port out_ready, input, [3:0]: per-lane downstream accept.
REQ-010 The block SHALL have port sel, output, [1:0]: lane currently owning the shared path, for driving the 4-to-1 mux and 1-to-4 demux selects.

Function
REQ-011 The block SHALL route lane k input to lane k output only, through one shared WIDTH-bit holding register.
REQ-012 The block SHALL implement a two-state FSM: IDLE (register empty) and HOLD (register full).
REQ-013 The block SHALL keep a 2-bit round-robin pointer ptr; grant g is the first lane with in_valid set, searching ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-014 The block SHALL set can_load = (state==IDLE) or (state==HOLD and out_ready[sel]).
REQ-015 The block SHALL drive in_ready[g]=1 only when can_load and in_valid non-zero; all other in_ready bits are 0.
REQ-016 A transfer SHALL occur when in_valid[g] and in_ready[g]; on it the block loads hold_data<=in_data[g], sel<=g, ptr<=(g+1) mod 4, next state HOLD.
REQ-017 In HOLD the block SHALL drive out_valid[sel]=1, out_data[sel]=hold_data, all other out_valid bits 0 and other out_data lanes all-zero.
REQ-018 In IDLE the block SHALL drive out_valid=4'b0000 and out_data all-zero.
REQ-019 Latency SHALL be one cycle: a transfer at edge t makes out_valid visible after edge t.
REQ-020 Drain without reload (HOLD, out_ready[sel]=1, no in_valid) SHALL go to IDLE; sel and ptr are unchanged.
REQ-021 Simultaneous drain and load SHALL stay in HOLD with new data, giving one transfer per cycle sustained.
REQ-022 In HOLD with out_ready[sel]=0 the block SHALL hold hold_data, sel, ptr and state, and drive in_ready=0.
REQ-023 out_ready bits of non-owning lanes SHALL be ignored.
REQ-024 in_valid deasserted before acceptance SHALL not move ptr; ptr advances only on a transfer.
REQ-025 With all four lanes continuously valid and out_ready all 1, grants SHALL rotate strictly, so each lane receives exactly one grant in every 4 consecutive transfers.

Reset
REQ-026 When rst=1 at a clock edge the block SHALL set state=IDLE, ptr=0, sel=0, hold_data=0, discarding any held payload.
REQ-027 While rst=1 the block SHALL drive in_ready=0, out_valid=0 and out_data all-zero; no transfer counts as accepted.
REQ-028 Reset asserted mid-HOLD SHALL take effect at the next edge regardless of out_ready.
REQ-029 After rst falls, the first grant search SHALL start at lane 0.

Verification
REQ-030 Single lane: after reset, in_valid=4'b0100, in_data[2]=2'b11, out_ready=4'b1111 -> in_ready=4'b0100; next cycle out_valid=4'b0100, out_data[2]=2'b11, sel=2, other out_data lanes 0.
REQ-031 Fairness: in_valid=4'b1111 held, out_ready=4'b1111 -> grant order 0,1,2,3,0,...; one transfer per cycle, no bubbles.
REQ-032 Backpressure: HOLD on lane 1, out_ready[1]=0 for 3 cycles, out_ready[0]=1 -> in_ready=0 and out_data[1] stable all 3 cycles; release -> drain and next grant same cycle.
REQ-033 Pointer skip: ptr=3, in_valid=4'b0011 -> grant lane 0, then ptr=1, next grant lane 1.
REQ-034 Reset mid-operation: HOLD on lane 3 with out_ready=0, assert rst one cycle -> out_valid=0, sel=0, ptr=0; first grant after reset with in_valid=4'b1001 is lane 0.
REQ-035 Drain to idle: single transfer, then in_valid=0, out_ready[sel]=1 -> out_valid=0 next cycle, sel retains last lane.

Source files
------------

// File: rtl/rr_xbar_sched_4.sv
// rr_xbar_sched_4: four-lane round-robin scheduler that moves one payload
// at a time from input lane k to output lane k through a single shared
// WIDTH-bit holding register. A load and a drain can overlap in the same
// cycle, so a continuously valid source gets one transfer per cycle.
module rr_xbar_sched_4 #(
   parameter int WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            in_valid,
   input  logic [3:0][WIDTH-1:0] in_data,
   output logic [3:0]            in_ready,
   output logic [3:0]            out_valid,
   output logic [3:0][WIDTH-1:0] out_data,
   input  logic [3:0]            out_ready,
   output logic [1:0]            sel
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t           state, state_nx;
   logic [1:0]       ptr, ptr_nx, sel_nx;
   logic [WIDTH-1:0] hold_data, hold_data_nx;

   logic [1:0] grant;
   logic [1:0] idx;
   logic       gnt_found;
   logic       can_load;
   logic       xfer;

   // Grant search: first valid lane starting at ptr, wrapping mod 4.
   always_comb begin
      grant     = ptr;
      gnt_found = 1'b0;
      idx       = ptr;
      for (int i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!gnt_found && in_valid[idx]) begin
            grant     = idx;
            gnt_found = 1'b1;
         end
      end
   end

   // Next-state and output decode; reset masks every handshake and output.
   always_comb begin
      state_nx     = state;
      ptr_nx       = ptr;
      sel_nx       = sel;
      hold_data_nx = hold_data;
      in_ready     = 4'b0000;
      out_valid    = 4'b0000;
      out_data     = '0;

      // The register can accept new data when empty, or when the current
      // owner is draining it this cycle. Other lanes' out_ready are ignored.
      can_load = (state == IDLE) || out_ready[sel];
      xfer     = !rst && can_load && gnt_found;

      if (xfer) begin
         in_ready[grant] = 1'b1;
      end

      if (!rst && (state == HOLD)) begin
         out_valid[sel] = 1'b1;
         out_data[sel]  = hold_data;
      end

      if (xfer) begin
         state_nx     = HOLD;
         hold_data_nx = in_data[grant];
         sel_nx       = grant;
         ptr_nx       = grant + 2'd1;
      end else if ((state == HOLD) && out_ready[sel]) begin
         // Drain with nothing to reload: sel and ptr keep their values.
         state_nx = IDLE;
      end
   end

   // State register; reset empties the holding register and restarts at lane 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 2'd0;
         sel       <= 2'd0;
         hold_data <= '0;
      end else begin
         state     <= state_nx;
         ptr       <= ptr_nx;
         sel       <= sel_nx;
         hold_data <= hold_data_nx;
      end
   end

endmodule

// File: tb/tb_rr_xbar_sched_4.sv
// tb_rr_xbar_sched_4: directed scenarios followed by random traffic, each
// cycle checked against a transaction-level model of the scheduler.
module tb_rr_xbar_sched_4;

   localparam int W = 2;

   logic              clk;
   logic              rst;
   logic [3:0]        in_valid;
   logic [3:0][W-1:0] in_data;
   logic [3:0]        in_ready;
   logic [3:0]        out_valid;
   logic [3:0][W-1:0] out_data;
   logic [3:0]        out_ready;
   logic [1:0]        sel;

   int checks;
   int failures;

   // Model: is a payload parked, which lane owns it, what it is, and where
   // the next round-robin search begins.
   bit         m_held;
   int         m_lane;
   int         m_ptr;
   logic [W-1:0] m_data;
   int         last_g;

   rr_xbar_sched_4 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .sel       (sel)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, check against the model, clock, advance the model.
   task automatic cycle(input logic [3:0] iv, input logic [3:0][W-1:0] id,
                        input logic [3:0] ordy, input logic r);
      int                g;
      int                l;
      bit                can;
      logic [3:0]        exp_ir;
      logic [3:0]        exp_ov;
      logic [3:0][W-1:0] exp_od;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      rst       = r;
      #1;
      g = -1;
      for (int k = 0; k < 4; k++) begin
         l = (m_ptr + k) % 4;
         if (g < 0 && iv[l]) g = l;
      end
      can    = !m_held || ordy[m_lane];
      exp_ir = 4'b0000;
      if (!r && can && g >= 0) exp_ir[g] = 1'b1;
      exp_ov = 4'b0000;
      exp_od = '0;
      if (!r && m_held) begin
         exp_ov[m_lane] = 1'b1;
         exp_od[m_lane] = m_data;
      end
      chk("in_ready", 32'(in_ready), 32'(exp_ir));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("out_data", 32'(out_data), 32'(exp_od));
      chk("sel", 32'(sel), 32'(m_lane));
      last_g = (exp_ir != 4'b0000) ? g : -1;
      @(posedge clk);
      if (r) begin
         m_held = 1'b0;
         m_lane = 0;
         m_ptr  = 0;
         m_data = '0;
      end else if (exp_ir != 4'b0000) begin
         m_held = 1'b1;
         m_lane = g;
         m_ptr  = (g + 1) % 4;
         m_data = id[g];
      end else if (m_held && ordy[m_lane]) begin
         m_held = 1'b0;
      end
      #1;
   endtask

   function automatic logic [3:0][W-1:0] lane_data(input logic [W-1:0] d0, d1, d2, d3);
      logic [3:0][W-1:0] v;
      v[0] = d0; v[1] = d1; v[2] = d2; v[3] = d3;
      return v;
   endfunction

   // Directed scenarios then random traffic, one linear sequence.
   initial begin
      logic [3:0][W-1:0] rd;
      logic [W-1:0]      held_val;
      checks   = 0;
      failures = 0;
      m_held   = 1'b0;
      m_lane   = 0;
      m_ptr    = 0;
      m_data   = '0;
      last_g   = -1;
      in_valid = 4'b0000;
      in_data  = '0;
      out_ready = 4'b0000;
      rst      = 1'b1;
      @(posedge clk);
      #1;

      // Reset held with requests present: nothing accepted or presented.
      cycle(4'b1111, lane_data(2'd1, 2'd2, 2'd3, 2'd1), 4'b1111, 1'b1);
      chk("rst_sel", 32'(sel), 32'd0);

      // Single lane 2 transfer, then presented on lane 2 only.
      cycle(4'b0100, lane_data(2'd0, 2'd0, 2'b11, 2'd0), 4'b1111, 1'b0);
      chk("single_grant", 32'(last_g), 32'd2);
      cycle(4'b0000, '0, 4'b0000, 1'b0);
      chk("single_ov", 32'(out_valid), 32'b0100);
      chk("single_od", 32'(out_data), 32'(lane_data(2'd0, 2'd0, 2'b11, 2'd0)));
      chk("single_sel", 32'(sel), 32'd2);

      // Drain to idle: out_valid drops, sel keeps the last lane.
      cycle(4'b0000, '0, 4'b1111, 1'b0);
      cycle(4'b0000, '0, 4'b1111, 1'b0);
      chk("drain_ov", 32'(out_valid), 32'd0);
      chk("drain_sel", 32'(sel), 32'd2);

      // Fairness from reset: strict rotation 0,1,2,3,0,... with no bubbles.
      cycle(4'b0000, '0, 4'b1111, 1'b1);
      for (int i = 0; i < 9; i++) begin
         cycle(4'b1111, lane_data(2'(i), 2'(i + 1), 2'(i + 2), 2'(i + 3)), 4'b1111, 1'b0);
         chk("fair_grant", 32'(last_g), 32'(i % 4));
      end

      // Backpressure on lane 1 while a non-owner lane signals ready.
      cycle(4'b0000, '0, 4'b1111, 1'b1);
      cycle(4'b0010, lane_data(2'd0, 2'b10, 2'd0, 2'd0), 4'b1111, 1'b0);
      held_val = 2'b10;
      for (int i = 0; i < 3; i++) begin
         cycle(4'b1111, lane_data(2'd3, 2'd1, 2'd3, 2'd3), 4'b0001, 1'b0);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_hold", 32'(out_data[1]), 32'(held_val));
      end
      cycle(4'b1111, lane_data(2'd3, 2'd1, 2'd1, 2'd3), 4'b1111, 1'b0);
      chk("bp_release_grant", 32'(last_g), 32'd2);

      // Pointer wrap: ptr at 3 with lanes 0 and 1 requesting.
      cycle(4'b0000, '0, 4'b1111, 1'b1);
      cycle(4'b0100, lane_data(2'd0, 2'd0, 2'd1, 2'd0), 4'b1111, 1'b0);
      cycle(4'b0011, lane_data(2'd2, 2'd3, 2'd0, 2'd0), 4'b1111, 1'b0);
      chk("skip_grant0", 32'(last_g), 32'd0);
      cycle(4'b0011, lane_data(2'd2, 2'd3, 2'd0, 2'd0), 4'b1111, 1'b0);
      chk("skip_grant1", 32'(last_g), 32'd1);

      // Reset while holding on lane 3 under backpressure.
      cycle(4'b1000, lane_data(2'd0, 2'd0, 2'd0, 2'd3), 4'b1111, 1'b0);
      cycle(4'b0000, '0, 4'b0000, 1'b0);
      chk("mid_hold_ov", 32'(out_valid), 32'b1000);
      cycle(4'b1001, lane_data(2'd1, 2'd0, 2'd0, 2'd2), 4'b0000, 1'b1);
      chk("mid_rst_ov", 32'(out_valid), 32'd0);
      cycle(4'b1001, lane_data(2'd1, 2'd0, 2'd0, 2'd2), 4'b0000, 1'b0);
      chk("post_rst_sel", 32'(sel), 32'd0);
      chk("post_rst_grant", 32'(last_g), 32'd0);

      // Random traffic with occasional reset.
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < 4; k++) rd[k] = W'($urandom);
         cycle(4'($urandom), rd, 4'($urandom), ($urandom_range(0, 39) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
